// File: rtl/step_m_seq_if.sv
// step_m_seq_if - command / status bundle for the stepper phase sequencer.
//   cmd_valid/cmd_ready  move-command handshake
//   cmd_dir/cmd_half     direction (1 = reverse) and half-step select
//   cmd_steps/cmd_div    step count and step period minus one (clk0 cycles)
//   abort, enable        stop the current move / coil drive enable
//   busy, done           move in progress / one-cycle completion pulse
//   steps_left, out      remaining steps and 4-bit coil pattern
// master = motion controller side, slave = sequencer side.
interface step_m_seq_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic             cmd_half;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic             enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;
  logic [3:0]       out;

  modport master (
    output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_div, abort, enable,
    input  cmd_ready, busy, done, steps_left, out
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_div, abort, enable,
    output cmd_ready, busy, done, steps_left, out
  );
endinterface

// File: rtl/step_m_seq.sv
// step_m_seq - parametrised stepper-motor phase sequencer.
// Accepts counted moves (direction, half/full step, rate divider) and walks
// a 3-bit phase index through the 8-entry half-step coil table.
// Ports:
//   clk0  system clock, rising edge
//   rst   synchronous reset, active high
//   bus   step_m_seq_if.slave: command handshake, abort/enable, status, coil out
module step_m_seq #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_W     = 16,
  parameter bit          IDLE_HOLD = 1'b1
) (
  input  logic         clk0,
  input  logic         rst,
  step_m_seq_if.slave  bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [2:0]       p;
  logic [CNT_W-1:0] left;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_r;
  logic             dir_r;
  logic             half_r;
  logic             done_r;

  logic             accept;
  logic             zero_cmd;
  logic             tick;
  logic             last;
  logic [2:0]       stride;
  logic [2:0]       p_nxt;

  function automatic logic [3:0] phase(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1001;
      3'd1:    pat = 4'b1000;
      3'd2:    pat = 4'b1100;
      3'd3:    pat = 4'b0100;
      3'd4:    pat = 4'b0110;
      3'd5:    pat = 4'b0010;
      3'd6:    pat = 4'b0011;
      default: pat = 4'b0001;
    endcase
    return pat;
  endfunction

  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign zero_cmd = (bus.cmd_steps == '0);
  assign tick     = (state == RUN) && (cnt == div_r);
  assign last     = (left == CNT_W'(1));

  // A full-step move starting on an odd index takes a single +/-1 step to
  // land on a two-coil pattern; after that p stays even and strides by 2.
  assign stride = (half_r || p[0]) ? 3'd1 : 3'd2;
  assign p_nxt  = dir_r ? (p - stride) : (p + stride);

  // State register
  always_ff @(posedge clk0) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort outranks a coincident tick
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.cmd_valid && !zero_cmd) state_nxt = RUN;
      RUN: begin
        if (bus.abort)        state_nxt = IDLE;
        else if (tick && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cmd_ready  = (state == IDLE);
    bus.busy       = (state == RUN);
    bus.done       = done_r;
    bus.steps_left = left;
    bus.out        = '0;
    if (bus.enable && ((state == RUN) || IDLE_HOLD)) bus.out = phase(p);
  end

  // Datapath: latched command, divider, phase index, step counter
  always_ff @(posedge clk0) begin
    if (rst) begin
      p      <= '0;
      left   <= '0;
      cnt    <= '0;
      div_r  <= '0;
      dir_r  <= 1'b0;
      half_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        dir_r  <= bus.cmd_dir;
        half_r <= bus.cmd_half;
        div_r  <= bus.cmd_div;
        left   <= bus.cmd_steps;
        cnt    <= '0;
        if (zero_cmd) done_r <= 1'b1;
      end else if (state == RUN && !bus.abort) begin
        if (tick) begin
          p    <= p_nxt;
          left <= left - CNT_W'(1);
          cnt  <= '0;
          if (last) done_r <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_step_m_seq.sv
module tb_step_m_seq;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 16;

  logic clk0;
  logic rst;

  step_m_seq_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();
  step_m_seq_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus2 ();

  step_m_seq #(.CNT_W(CNT_W), .DIV_W(DIV_W), .IDLE_HOLD(1'b1)) dut (
    .clk0(clk0),
    .rst (rst),
    .bus (bus)
  );

  step_m_seq #(.CNT_W(CNT_W), .DIV_W(DIV_W), .IDLE_HOLD(1'b0)) dut_nohold (
    .clk0(clk0),
    .rst (rst),
    .bus (bus2)
  );

  // Second instance sees the identical stimulus
  assign bus2.cmd_valid = bus.cmd_valid;
  assign bus2.cmd_dir   = bus.cmd_dir;
  assign bus2.cmd_half  = bus.cmd_half;
  assign bus2.cmd_steps = bus.cmd_steps;
  assign bus2.cmd_div   = bus.cmd_div;
  assign bus2.abort     = bus.abort;
  assign bus2.enable    = bus.enable;

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a move is "wait div+1 edges, take one step", repeated.
  logic [3:0] tbl [8];
  bit m_run;
  bit m_done;
  int m_p;
  int m_left;
  int m_wait;
  int m_div;
  bit m_dir;
  bit m_half;

  task automatic model_edge();
    bit nd;
    int d;
    nd = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_p = 0; m_left = 0;
    end else if (!m_run) begin
      if (bus.cmd_valid) begin
        m_dir  = bus.cmd_dir;
        m_half = bus.cmd_half;
        m_div  = int'(bus.cmd_div);
        m_left = int'(bus.cmd_steps);
        m_wait = m_div + 1;
        if (m_left == 0) nd = 1'b1;
        else             m_run = 1'b1;
      end
    end else if (bus.abort) begin
      m_run = 1'b0;
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        d = (m_half || (m_p % 2 == 1)) ? 1 : 2;
        m_p = (m_p + (m_dir ? 8 - d : d)) % 8;
        m_left--;
        m_wait = m_div + 1;
        if (m_left == 0) begin
          m_run = 1'b0;
          nd = 1'b1;
        end
      end
    end
    m_done = nd;
  endtask

  function automatic logic [3:0] exp_out(input bit hold);
    return (bus.enable && (m_run || hold)) ? tbl[m_p] : 4'b0000;
  endfunction

  task automatic tick_check();
    @(posedge clk0);
    model_edge();
    #1;
    chk("out",        32'(bus.out),        32'(exp_out(1'b1)));
    chk("out_nohold", 32'(bus2.out),       32'(exp_out(1'b0)));
    chk("busy",       32'(bus.busy),       32'(m_run));
    chk("cmd_ready",  32'(bus.cmd_ready),  32'(!m_run));
    chk("done",       32'(bus.done),       32'(m_done));
    chk("steps_left", 32'(bus.steps_left), 32'(m_left));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick_check();
    rst = 1'b0;
  endtask

  task automatic issue(input bit dir, input bit half, input int steps, input int div);
    bus.cmd_dir   = dir;
    bus.cmd_half  = half;
    bus.cmd_steps = CNT_W'(steps);
    bus.cmd_div   = DIV_W'(div);
    bus.cmd_valid = 1'b1;
    tick_check();
    // Scramble the command fields: a running move must ignore them
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'($urandom);
    bus.cmd_half  = 1'($urandom);
    bus.cmd_steps = CNT_W'($urandom);
    bus.cmd_div   = DIV_W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick_check();
      n++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    tbl[0] = 4'b1001; tbl[1] = 4'b1000; tbl[2] = 4'b1100; tbl[3] = 4'b0100;
    tbl[4] = 4'b0110; tbl[5] = 4'b0010; tbl[6] = 4'b0011; tbl[7] = 4'b0001;
    m_run = 1'b0; m_done = 1'b0; m_p = 0; m_left = 0; m_wait = 0;
    m_div = 0; m_dir = 1'b0; m_half = 1'b0;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_half = 1'b0;
    bus.cmd_steps = '0;   bus.cmd_div = '0;   bus.abort = 1'b0;
    bus.enable = 1'b1;

    // Reset state
    do_reset();
    chk("rst_out",   32'(bus.out),        32'h9);
    chk("rst_ready", 32'(bus.cmd_ready),  32'd1);
    chk("rst_left",  32'(bus.steps_left), 32'd0);

    // Forward half-step, 3 steps, div=1
    issue(1'b0, 1'b1, 3, 1);
    tick_check(); tick_check(); chk("t2_e2", 32'(bus.out), 32'h8);
    tick_check(); tick_check(); chk("t2_e4", 32'(bus.out), 32'hC);
    tick_check(); tick_check(); chk("t2_e6", 32'(bus.out), 32'h4);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_busy", 32'(bus.busy), 32'd0);
    tick_check(); chk("t2_done_off", 32'(bus.done), 32'd0);

    // Reverse half-step wrap 0->7->6
    do_reset();
    issue(1'b1, 1'b1, 2, 0);
    tick_check(); chk("t3_e1", 32'(bus.out), 32'h1);
    tick_check(); chk("t3_e2", 32'(bus.out), 32'h3);

    // Full-step from an odd index realigns first
    do_reset();
    issue(1'b0, 1'b1, 1, 0);
    tick_check();
    issue(1'b0, 1'b0, 3, 0);
    tick_check(); chk("t4_e1", 32'(bus.out), 32'hC);
    tick_check(); chk("t4_e2", 32'(bus.out), 32'h6);
    tick_check(); chk("t4_e3", 32'(bus.out), 32'h3);
    tick_check();

    // Abort after the 4th tick
    do_reset();
    issue(1'b0, 1'b1, 10, 3);
    repeat (16) tick_check();
    bus.abort = 1'b1;
    tick_check();
    bus.abort = 1'b0;
    chk("t5_left", 32'(bus.steps_left), 32'd6);
    chk("t5_out",  32'(bus.out),        32'h6);
    chk("t5_busy", 32'(bus.busy),       32'd0);
    tick_check();
    chk("t5_nodone", 32'(bus.done), 32'd0);

    // Abort coincident with the final tick
    issue(1'b0, 1'b1, 2, 1);
    repeat (3) tick_check();
    bus.abort = 1'b1;
    tick_check();
    bus.abort = 1'b0;
    chk("t5b_left", 32'(bus.steps_left), 32'd1);
    chk("t5b_done", 32'(bus.done),       32'd0);
    tick_check();

    // Zero-step command
    issue(1'b0, 1'b1, 0, 2);
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_out",  32'(bus.out),  32'h2);
    tick_check();

    // Coils off mid-move, sequencing continues
    issue(1'b1, 1'b1, 4, 0);
    bus.enable = 1'b0;
    tick_check(); tick_check();
    chk("t6_en_off", 32'(bus.out), 32'h0);
    bus.enable = 1'b1;
    wait_idle(20);
    tick_check();

    // Reset mid-move
    issue(1'b0, 1'b0, 8, 1);
    repeat (5) tick_check();
    rst = 1'b1;
    tick_check();
    rst = 1'b0;
    chk("t6_rst_out",  32'(bus.out),  32'h9);
    chk("t6_rst_done", 32'(bus.done), 32'd0);
    tick_check();
    chk("t6_rst_done2", 32'(bus.done), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.cmd_valid = ($urandom_range(0, 3) == 0);
      bus.cmd_dir   = 1'($urandom);
      bus.cmd_half  = 1'($urandom);
      bus.cmd_steps = CNT_W'($urandom_range(0, 6));
      bus.cmd_div   = DIV_W'($urandom_range(0, 3));
      bus.abort     = ($urandom_range(0, 29) == 0);
      bus.enable    = ($urandom_range(0, 7) != 0);
      tick_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
